fifo_burst_reader: RTL and testbench

- Read-side drain engine for `asyncfifo`. Sits in the read clock domain.
- On command, pulls exactly `cmd_len` words through the FIFO read port (`rpull`/`rempty`/`rdata`).
- Presents the words on a valid/ready stream with a 2-entry output buffer, and flags the final word.
- Replaces hand-written pull loops in consumers; gives full throughput and clean backpressure.

---
 rtl/fifo_burst_reader.sv | 181 ++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side drain engine for asyncfifo.
// On cmd_start it pops exactly cmd_len words from a first-word fall-through
// FIFO and replays them on a valid/ready stream through a 2-entry skid
// buffer, tagging the final word with m_last and pulsing done afterwards.
// rpull is a function of registered state and rempty only, so downstream
// backpressure never reaches the FIFO pop combinationally.

module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  rpull,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    busy_r;
    logic                    done_r;
    logic [LEN_W-1:0]        pull_rem_r;
    logic [LEN_W-1:0]        out_rem_r;
    logic [1:0]              buf_cnt_r;
    logic [DATA_WIDTH-1:0]   buf_head_r;
    logic [DATA_WIDTH-1:0]   buf_tail_r;

    logic                    valid_s;
    logic                    pull_ok_s;
    logic                    pull_s;
    logic                    pop_s;
    logic                    last_s;
    logic                    final_hs_s;

    // Pull/handshake decode: pull only from registered state plus rempty.
    always_comb begin
        valid_s    = (buf_cnt_r != 2'd0);
        pull_ok_s  = (pull_rem_r != LEN_ZERO) && (buf_cnt_r != 2'd2);
        if (state_r == ST_DRAIN) begin
            pull_s = (!rempty) && pull_ok_s;
        end else begin
            pull_s = 1'b0;
        end
        pop_s      = valid_s && m_ready;
        last_s     = valid_s && (out_rem_r == LEN_ONE);
        final_hs_s = pop_s && (out_rem_r == LEN_ONE);
    end

    // Burst sequencer: owns state, word counters and the busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pull_rem_r <= LEN_ZERO;
            out_rem_r  <= LEN_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_start) begin
                        pull_rem_r <= cmd_len;
                        out_rem_r  <= cmd_len;
                        if (cmd_len != LEN_ZERO) begin
                            state_r <= ST_DRAIN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Counters only move while nonzero, so they never wrap.
                    if (pull_s && (pull_rem_r != LEN_ZERO)) begin
                        pull_rem_r <= pull_rem_r - LEN_ONE;
                    end
                    if (pop_s && (out_rem_r != LEN_ZERO)) begin
                        out_rem_r <= out_rem_r - LEN_ONE;
                    end
                    if (final_hs_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    pull_rem_r <= LEN_ZERO;
                    out_rem_r  <= LEN_ZERO;
                end
            endcase
        end
    end

    // Two-entry output buffer: head drives m_data, tail absorbs one stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt_r  <= 2'd0;
            buf_head_r <= {DATA_WIDTH{1'b0}};
            buf_tail_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (buf_cnt_r)
                2'd0: begin
                    if (pull_s) begin
                        buf_head_r <= rdata;
                        buf_cnt_r  <= 2'd1;
                    end else begin
                        buf_cnt_r  <= 2'd0;
                    end
                end
                2'd1: begin
                    if (pull_s && pop_s) begin
                        buf_head_r <= rdata;
                        buf_cnt_r  <= 2'd1;
                    end else if (pull_s) begin
                        buf_tail_r <= rdata;
                        buf_cnt_r  <= 2'd2;
                    end else if (pop_s) begin
                        buf_cnt_r  <= 2'd0;
                    end else begin
                        buf_cnt_r  <= 2'd1;
                    end
                end
                2'd2: begin
                    // No pull is possible here, so a pop just shifts tail to head.
                    if (pop_s) begin
                        buf_head_r <= buf_tail_r;
                        buf_cnt_r  <= 2'd1;
                    end else begin
                        buf_cnt_r  <= 2'd2;
                    end
                end
                default: begin
                    buf_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rpull   = pull_s;
    assign m_valid = valid_s;
    assign m_data  = buf_head_r;
    assign m_last  = last_s;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: a queue-based FIFO model feeds the
// DUT, and a transaction-level reference (expected word stream, outstanding
// word list, remaining-word counts) predicts every output each cycle.

module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          done;
    logic          rpull;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .done      (done),
        .rpull     (rpull),
        .rempty    (rempty),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    int total = 0;
    int bad   = 0;

    // FIFO contents, words still to be released into it, words popped but
    // not yet delivered, and the word stream the burst must produce.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] held_q[$];
    logic [DW-1:0] ref_q[$];

    int pulls_left = 0;
    int out_left   = 0;
    bit exp_busy   = 1'b0;
    bit done_due   = 1'b0;
    int bursts_done = 0;
    int pops_total  = 0;
    int hs_total    = 0;
    int tick        = 0;
    int gap         = 1;
    int ready_mode  = 0;
    bit poke        = 1'b0;
    bit chk_en      = 1'b0;
    bit after_rst   = 1'b0;
    bit stalled     = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? {DW{1'b0}} : fifo_q[0];
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((tick % 2) == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        if (poke) begin
            if (exp_busy) begin
                cmd_start = 1'($urandom_range(0, 1));
                cmd_len   = 8'($urandom);
            end else begin
                cmd_start = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        bit exp_rpull, idle, next_done, s_pop, s_hs, s_start, s_rst;
        logic [LW-1:0] s_len;
        logic [DW-1:0] s_data, w;
        int cnt;
        @(negedge clk);
        cnt = held_q.size();
        if (chk_en) begin
            exp_rpull = exp_busy && !rempty && (pulls_left != 0) && (cnt != 2);
            check_eq("rpull", 64'(rpull), 64'(exp_rpull));
            check_eq("m_valid", 64'(m_valid), 64'(cnt != 0));
            check_eq("busy", 64'(busy), 64'(exp_busy));
            check_eq("done", 64'(done), 64'(done_due));
            check_eq("m_last", 64'(m_last), 64'((cnt != 0) && (out_left == 1)));
            check_eq("buf_depth", 64'(cnt <= 2), 64'(1));
            if (cnt != 0) check_eq("m_data", 64'(m_data), 64'(held_q[0]));
            if (after_rst) check_eq("rst_m_data", 64'(m_data), 64'(0));
            if (stalled) begin
                check_eq("stall_data", 64'(m_data), 64'(prev_data));
                check_eq("stall_last", 64'(m_last), 64'(prev_last));
            end
        end
        s_pop   = (rpull === 1'b1) && (rempty === 1'b0);
        s_hs    = (m_valid === 1'b1) && (m_ready === 1'b1);
        s_start = (cmd_start === 1'b1);
        s_rst   = (rst === 1'b1);
        s_len   = cmd_len;
        s_data  = m_data;
        stalled = (m_valid === 1'b1) && (m_ready === 1'b0);
        prev_data = m_data;
        prev_last = m_last;
        idle = !exp_busy && !done_due;
        @(posedge clk);
        #1;
        tick++;
        next_done = 1'b0;
        if (done_due) bursts_done++;
        if (s_hs && !s_rst && (cnt > 0)) begin
            void'(held_q.pop_front());
            if (ref_q.size() > 0) check_eq("order", 64'(s_data), 64'(ref_q.pop_front()));
            else                  check_eq("extra_hs", 64'(s_hs), 64'(0));
            hs_total++;
            if (out_left > 0) begin
                out_left--;
                if (out_left == 0) begin
                    exp_busy  = 1'b0;
                    next_done = 1'b1;
                end
            end
        end
        if (s_pop) begin
            w = fifo_q.pop_front();
            pops_total++;
            if (!s_rst) begin
                held_q.push_back(w);
                if (pulls_left > 0) pulls_left--;
            end
        end
        if (s_start && idle && !s_rst) begin
            pulls_left = int'(s_len);
            out_left   = int'(s_len);
            if (s_len == 8'd0) next_done = 1'b1;
            else               exp_busy  = 1'b1;
        end
        done_due = next_done;
        if (s_rst) begin
            held_q.delete();
            exp_busy   = 1'b0;
            done_due   = 1'b0;
            pulls_left = 0;
            out_left   = 0;
            stalled    = 1'b0;
        end
        after_rst = s_rst;
        if ((feed_q.size() > 0) && ((tick % gap) == 0)) fifo_q.push_back(feed_q.pop_front());
        drive_inputs();
    endtask

    task automatic run_burst(input int len, input int mode, input bit poke_en);
        int b0, p0, budget;
        b0 = bursts_done;
        p0 = pops_total;
        budget = 0;
        ready_mode = mode;
        drive_inputs();
        cmd_start = 1'b1;
        cmd_len   = 8'(len);
        cycle();
        cmd_start = 1'b0;
        poke = poke_en;
        while ((bursts_done == b0) && (budget < 3000)) begin
            cycle();
            budget++;
        end
        poke = 1'b0;
        cmd_start = 1'b0;
        check_eq("burst_finished", 64'(bursts_done), 64'(b0 + 1));
        check_eq("pop_count", 64'(pops_total - p0), 64'(len));
        check_eq("ref_drained", 64'(ref_q.size()), 64'(0));
    endtask

    initial begin
        int len, extra, b0, h0, budget;
        logic [DW-1:0] w;
        rst = 1'b1; cmd_start = 1'b0; cmd_len = 8'd0;
        m_ready = 1'b0; rempty = 1'b1; rdata = {DW{1'b0}};
        @(posedge clk);
        #1;
        cycle();
        chk_en = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();

        // Basic drain, then backpressure, of words 2..17.
        for (int m = 0; m < 2; m++) begin
            for (int i = 2; i <= 17; i++) begin
                fifo_q.push_back(DW'(i));
                ref_q.push_back(DW'(i));
            end
            run_burst(16, m, 1'b0);
            check_eq("fifo_left_basic", 64'(fifo_q.size()), 64'(0));
            cycle();
        end

        // Starved FIFO: one word every 5 cycles.
        gap = 5;
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            feed_q.push_back(w);
            ref_q.push_back(w);
        end
        run_burst(4, 0, 1'b0);
        gap = 1;
        cycle();

        // Over-full FIFO: 10 words, burst of 3.
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            if (i < 3) ref_q.push_back(w);
        end
        run_burst(3, 2, 1'b0);
        check_eq("fifo_retained", 64'(fifo_q.size()), 64'(7));
        fifo_q.delete();
        cycle();

        // Zero length burst, then ignored commands during DRAIN.
        run_burst(0, 0, 1'b0);
        cycle();
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            ref_q.push_back(w);
        end
        run_burst(16, 2, 1'b1);
        cycle();

        // Reset after 5 of 16 words; no done, then a clean 2-word burst.
        for (int i = 2; i <= 17; i++) begin
            fifo_q.push_back(DW'(i));
            ref_q.push_back(DW'(i));
        end
        b0 = bursts_done;
        h0 = hs_total;
        ready_mode = 0;
        drive_inputs();
        cmd_start = 1'b1;
        cmd_len   = 8'd16;
        cycle();
        cmd_start = 1'b0;
        budget = 0;
        while (((hs_total - h0) < 5) && (budget < 200)) begin
            cycle();
            budget++;
        end
        check_eq("hs_before_rst", 64'(hs_total - h0), 64'(5));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        ref_q.delete();
        fifo_q.delete();
        drive_inputs();
        for (int i = 0; i < 4; i++) cycle();
        check_eq("no_done_after_rst", 64'(bursts_done), 64'(b0));
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            ref_q.push_back(w);
        end
        run_burst(2, 0, 1'b0);
        cycle();

        // Maximum length burst.
        for (int i = 0; i < 260; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            if (i < 255) ref_q.push_back(w);
        end
        run_burst(255, 0, 1'b0);
        check_eq("fifo_left_max", 64'(fifo_q.size()), 64'(5));
        fifo_q.delete();
        cycle();

        // Random bursts: random length, FIFO rate, backpressure and pokes.
        for (int it = 0; it < 8; it++) begin
            len   = $urandom_range(1, 40);
            extra = $urandom_range(0, 5);
            gap   = $urandom_range(1, 3);
            for (int i = 0; i < len + extra; i++) begin
                w = $urandom;
                feed_q.push_back(w);
                if (i < len) ref_q.push_back(w);
            end
            run_burst(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            check_eq("fifo_left_rand", 64'(fifo_q.size() + feed_q.size()), 64'(extra));
            fifo_q.delete();
            feed_q.delete();
            gap = 1;
            drive_inputs();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
